mrc_ec_sign_resolve: RTL and testbench
======================================

// Module: mrc_ec_sign_resolve
// PURPOSE
//  Final stage of the error-correcting mixed-radix conversion pipeline; sits directly downstream of the
//  digit-8/9 stage and consumes its accumulated value d7_0_8 plus dual sign chains A/B (redundant copies).
//  Registers inputs, classifies each result as POS / NEG / OVERFLOW (redundant-digit error) / FAULT (A!=B),
//  emits value+class with valid, and keeps saturating error counters plus a first-error capture.
// PARAMETERS
//  DATA_WIDTH   18   width of d7_0_8 accumulated value
//  CNT_WIDTH    16   width of each saturating error counter
//  IN_LATENCY   0    extra valid delay (cycles) to align in_valid with upstream data; 0..15
// PORTS
//  clk           in   1           pipeline clock
//  reset         in   1           asynchronous, active-high reset
//  in_valid      in   1           upstream sample valid (pre-delay by IN_LATENCY)
//  d7_0_8_in     in   DATA_WIDTH  accumulated mixed-radix value from digit-8/9 stage
//  Sgn_in_A      in   2           sign chain A {neg_match,pos_match}
//  Sgn_in_B      in   2           sign chain B {neg_match,pos_match}
//  clr_err       in   1           synchronous clear of counters, sticky flag, capture
//  out_valid     out  1           result valid
//  d_out         out  DATA_WIDTH  registered value (zeroed when class is OVF or FAULT)
//  sgn_class     out  2           00 POS, 01 NEG, 10 OVF, 11 FAULT
//  err_sticky    out  1           set on any OVF/FAULT since reset/clear
//  ovf_cnt       out  CNT_WIDTH   count of OVF results, saturating at all-ones
//  fault_cnt     out  CNT_WIDTH   count of FAULT results, saturating
//  cap_valid     out  1           first-error capture holds data
//  cap_data      out  DATA_WIDTH  d7_0_8 of first error
//  cap_sgn       out  4           {Sgn_A,Sgn_B} of first error
// BEHAVIOUR
//  - Reset: every output and internal register 0 (sgn_class=00, out_valid=0, counters 0, cap_valid=0).
//  - in_valid passes IN_LATENCY-deep shift register (bypass when 0); data/sign sampled when delayed valid=1.
//  - Stage 1 (cycle N+1): register value, A, B, valid. Stage 2 (cycle N+2): classify, drive outputs.
//    Latency from delayed valid to out_valid = 2 cycles; full throughput, one result per cycle, no stall.
//  - Classification: A!=B -> FAULT; else A==01 -> POS; A==10 -> NEG; A==00 or 11 -> OVF.
//  - d_out = stage-1 value for POS/NEG, 0 for OVF/FAULT. Outputs hold last result when out_valid=0
//    (out_valid deasserts; data not cleared). Invalid slots never update counters or capture.
//  - Counters increment by 1 on qualifying valid result; at all-ones they hold (no wrap).
//  - err_sticky set on first OVF/FAULT; cap_* loaded only when cap_valid=0, then frozen.
//  - clr_err: clears counters, err_sticky, cap_*. Same-cycle clr_err and error result: error wins --
//    counter becomes 1, sticky=1, capture loads the new error.
//  - Reset mid-stream: in-flight samples discarded; first out_valid no earlier than 2+IN_LATENCY cycles
//    after the first post-reset in_valid.
// STRUCTURE
//  - Shared package: sign-class localparams (CLS_POS/NEG/OVF/FAULT), sign-chain codes (SGN_POS=01,
//    SGN_NEG=10), DATA_WIDTH default 18 shared with the digit stages.
//  - One sub-module: mrc_sat_counter (CNT_WIDTH, inc, clr, clr-vs-inc priority to inc) instanced twice.
//  - Valid delay line, 2-stage pipeline, classifier and capture logic inline.
// TESTING
//  1. Reset then in_valid=1, d=12345, A=B=01 -> 2 cycles later out_valid=1, d_out=12345, class=00, sticky=0.
//  2. A=B=10, d=262000 -> class=01, d_out=262000; counters stay 0.
//  3. A=B=00, d=777 -> class=10, d_out=0, ovf_cnt=1, sticky=1, cap_data=777, cap_sgn=4'b0000;
//     second OVF with d=888 -> ovf_cnt=2, cap_data stays 777.
//  4. A=01, B=10 -> class=11, fault_cnt=1; clr_err asserted same cycle the result registers -> fault_cnt=1.
//  5. Force ovf_cnt to 16'hFFFE, issue 3 OVF results -> counter reads FFFF and holds.
//  6. Back-to-back 8 valids with IN_LATENCY=3, reset asserted mid-burst -> all outputs 0 immediately,
//     no out_valid until 5 cycles after next in_valid.

Source files
------------

// File: rtl/mrc_ec_sign_resolve_pkg.sv
// Shared definitions for the mixed-radix error-correcting pipeline:
// sign-class encodings, sign-chain codes and the default value width.
package mrc_ec_sign_resolve_pkg;

  localparam int DATA_WIDTH_DEF = 18;

  // Result classes driven on sgn_class
  localparam logic [1:0] CLS_POS   = 2'b00;
  localparam logic [1:0] CLS_NEG   = 2'b01;
  localparam logic [1:0] CLS_OVF   = 2'b10;
  localparam logic [1:0] CLS_FAULT = 2'b11;

  // Sign-chain match codes {neg_match,pos_match}
  localparam logic [1:0] SGN_POS = 2'b01;
  localparam logic [1:0] SGN_NEG = 2'b10;

  // Disagreeing redundant chains are a fault. Otherwise exactly one match bit
  // must be set; none or both means the redundant digit went out of range.
  function automatic logic [1:0] classify(input logic [1:0] a, input logic [1:0] b);
    if (a != b)            return CLS_FAULT;
    else if (a == SGN_POS) return CLS_POS;
    else if (a == SGN_NEG) return CLS_NEG;
    else                   return CLS_OVF;
  endfunction

endpackage

// File: rtl/mrc_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear wins and restarts the count at 1.
module mrc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  // Count qualifying events, hold at all-ones, clear on request
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (inc) begin
      if (clr)               cnt <= CNT_WIDTH'(1);
      else if (cnt != '1)    cnt <= cnt + 1'b1;
    end
    else if (clr)            cnt <= '0;
  end

endmodule

// File: rtl/mrc_ec_sign_resolve.sv
// Final stage of the error-correcting mixed-radix conversion pipeline.
// Aligns the upstream valid, registers value and both sign chains, then
// classifies each result and tracks errors (counters, sticky, first capture).
module mrc_ec_sign_resolve
  import mrc_ec_sign_resolve_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16,
  parameter int IN_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] d7_0_8_in,
  input  logic [1:0]            Sgn_in_A,
  input  logic [1:0]            Sgn_in_B,
  input  logic                  clr_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [1:0]            sgn_class,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  cap_valid,
  output logic [DATA_WIDTH-1:0] cap_data,
  output logic [3:0]            cap_sgn
);

  // ---- valid alignment delay line (bit 0 is the raw input) ----
  logic [IN_LATENCY:0] vld_pipe;
  logic                dly_valid;

  assign vld_pipe[0] = in_valid;
  assign dly_valid   = vld_pipe[IN_LATENCY];

  generate
    if (IN_LATENCY > 0) begin : g_vdly
      // Shift valid forward so it lines up with the upstream data
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe[IN_LATENCY:1] <= '0;
        else       vld_pipe[IN_LATENCY:1] <= vld_pipe[IN_LATENCY-1:0];
      end
    end
  endgenerate

  // ---- stage 1: capture value and both sign chains ----
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [1:0]            s1_a, s1_b;

  // Sample data only on aligned valid slots so idle cycles keep the last sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= dly_valid;
      if (dly_valid) begin
        s1_data <= d7_0_8_in;
        s1_a    <= Sgn_in_A;
        s1_b    <= Sgn_in_B;
      end
    end
  end

  // ---- stage 2: classify and register outputs ----
  logic [1:0] cls;
  logic       is_ovf, is_fault, is_err;

  assign cls      = classify(s1_a, s1_b);
  assign is_ovf   = s1_valid && (cls == CLS_OVF);
  assign is_fault = s1_valid && (cls == CLS_FAULT);
  assign is_err   = is_ovf || is_fault;

  // Result outputs: only valid slots update, idle cycles hold the last result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sgn_class <= CLS_POS;
      d_out     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sgn_class <= cls;
        d_out     <= (cls == CLS_POS || cls == CLS_NEG) ? s1_data : '0;
      end
    end
  end

  // Sticky flag and first-error capture; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_sgn    <= '0;
    end else if (is_err) begin
      err_sticky <= 1'b1;
      if (!cap_valid || clr_err) begin
        cap_valid <= 1'b1;
        cap_data  <= s1_data;
        cap_sgn   <= {s1_a, s1_b};
      end
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_sgn    <= '0;
    end
  end

  mrc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (is_ovf),
    .clr   (clr_err),
    .cnt   (ovf_cnt)
  );

  mrc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (is_fault),
    .clr   (clr_err),
    .cnt   (fault_cnt)
  );

endmodule

// File: tb/tb_mrc_ec_sign_resolve.sv
// Bench for mrc_ec_sign_resolve: a zero-latency instance with a result
// scoreboard, and a small-counter IN_LATENCY=3 instance for saturation,
// mid-burst reset and aligned-latency checks.
module tb_mrc_ec_sign_resolve;

  localparam int DW  = 18;
  localparam int CW  = 16;
  localparam int CW3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- instance 0: IN_LATENCY=0 ----
  logic          rst0 = 1'b1, iv0 = 1'b0, clr0 = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [1:0]    a0 = '0, b0 = '0;
  logic          ov0, st0, cv0;
  logic [DW-1:0] do0, cd0;
  logic [1:0]    cls0;
  logic [CW-1:0] oc0, fc0;
  logic [3:0]    cs0;

  mrc_ec_sign_resolve #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .IN_LATENCY(0)) dut0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .d7_0_8_in(d0),
    .Sgn_in_A(a0), .Sgn_in_B(b0), .clr_err(clr0),
    .out_valid(ov0), .d_out(do0), .sgn_class(cls0), .err_sticky(st0),
    .ovf_cnt(oc0), .fault_cnt(fc0), .cap_valid(cv0), .cap_data(cd0), .cap_sgn(cs0)
  );

  // ---- instance 3: IN_LATENCY=3, 3-bit counters ----
  logic           rst3 = 1'b1, iv3 = 1'b0, clr3 = 1'b0;
  logic [DW-1:0]  d3 = '0;
  logic [1:0]     a3 = '0, b3 = '0;
  logic           ov3, st3, cv3;
  logic [DW-1:0]  do3, cd3;
  logic [1:0]     cls3;
  logic [CW3-1:0] oc3, fc3;
  logic [3:0]     cs3;

  mrc_ec_sign_resolve #(.DATA_WIDTH(DW), .CNT_WIDTH(CW3), .IN_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .in_valid(iv3), .d7_0_8_in(d3),
    .Sgn_in_A(a3), .Sgn_in_B(b3), .clr_err(clr3),
    .out_valid(ov3), .d_out(do3), .sgn_class(cls3), .err_sticky(st3),
    .ovf_cnt(oc3), .fault_cnt(fc3), .cap_valid(cv3), .cap_data(cd3), .cap_sgn(cs3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    cls;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  // Reference classification from the sign chains
  function automatic exp_t model(input logic [DW-1:0] d, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    if (a != b)          begin e.cls = 2'b11; e.d = '0; end
    else if (a == 2'b01) begin e.cls = 2'b00; e.d = d;  end
    else if (a == 2'b10) begin e.cls = 2'b01; e.d = d;  end
    else                 begin e.cls = 2'b10; e.d = '0; end
    return e;
  endfunction

  // Drive one valid slot on instance 0 (called at a negedge) and expect its result
  task automatic drive0(input logic [DW-1:0] d, input logic [1:0] a, input logic [1:0] b);
    iv0 = 1'b1; d0 = d; a0 = a; b0 = b;
    sb.push_back(model(d, a, b));
    @(negedge clk);
  endtask

  task automatic idle0(input int n);
    iv0 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: compare every instance-0 result against the queued expectation
  always @(negedge clk) begin
    if (!rst0 && ov0) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(ov0), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_class", 32'(cls0), 32'(e.cls));
        chk("sb_dout",  32'(do0),  32'(e.d));
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ovalid", 32'(ov0), 0);
    chk("rst_class",  32'(cls0), 0);
    chk("rst_dout",   32'(do0), 0);
    chk("rst_ovf",    32'(oc0), 0);
    chk("rst_fault",  32'(fc0), 0);
    chk("rst_sticky", 32'(st0), 0);
    chk("rst_capv",   32'(cv0), 0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    // 1: POS, two-cycle latency
    drive0(18'd12345, 2'b01, 2'b01);
    iv0 = 1'b0;
    chk("lat_early", 32'(ov0), 0);
    @(negedge clk);
    chk("lat_two", 32'(ov0), 1);
    idle0(2);
    chk("hold_ovalid", 32'(ov0), 0);
    chk("hold_dout",   32'(do0), 12345);
    chk("pos_sticky",  32'(st0), 0);

    // 2: NEG, counters untouched
    drive0(18'd262000, 2'b10, 2'b10);
    idle0(3);
    chk("neg_ovf",   32'(oc0), 0);
    chk("neg_fault", 32'(fc0), 0);

    // 3: OVF and first-error capture
    drive0(18'd777, 2'b00, 2'b00);
    idle0(3);
    chk("ovf1_cnt",   32'(oc0), 1);
    chk("ovf1_stk",   32'(st0), 1);
    chk("ovf1_capv",  32'(cv0), 1);
    chk("ovf1_capd",  32'(cd0), 777);
    chk("ovf1_caps",  32'(cs0), 0);
    drive0(18'd888, 2'b11, 2'b11);
    idle0(3);
    chk("ovf2_cnt",   32'(oc0), 2);
    chk("ovf2_capd",  32'(cd0), 777);

    // 4: FAULT with a same-cycle clear: error wins
    drive0(18'd555, 2'b01, 2'b10);
    iv0 = 1'b0; clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    chk("clr_fault", 32'(fc0), 1);
    chk("clr_ovf",   32'(oc0), 0);
    chk("clr_stk",   32'(st0), 1);
    chk("clr_capv",  32'(cv0), 1);
    chk("clr_capd",  32'(cd0), 555);
    chk("clr_caps",  32'(cs0), 4'b0110);
    idle0(2);

    // back-to-back mixed results at full rate
    drive0(18'd1,      2'b01, 2'b01);
    drive0(18'd2,      2'b10, 2'b10);
    drive0(18'd3,      2'b10, 2'b01);
    drive0(18'h3FFFF,  2'b01, 2'b01);
    drive0(18'd5,      2'b00, 2'b00);
    idle0(4);
    chk("b2b_fault", 32'(fc0), 2);
    chk("b2b_ovf",   32'(oc0), 1);
    chk("b2b_capd",  32'(cd0), 555);

    // plain clear with no error present
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    chk("pclr_fault", 32'(fc0), 0);
    chk("pclr_ovf",   32'(oc0), 0);
    chk("pclr_stk",   32'(st0), 0);
    chk("pclr_capv",  32'(cv0), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    // 5: saturation on the 3-bit counter: 10 OVFs must stop at 7
    iv3 = 1'b1; d3 = 18'd9; a3 = 2'b00; b3 = 2'b00;
    repeat (10) @(negedge clk);
    iv3 = 1'b0;
    repeat (8) @(negedge clk);
    chk("sat_cnt",   32'(oc3), 7);
    chk("sat_class", 32'(cls3), 2'b10);
    chk("sat_dout",  32'(do3), 0);
    clr3 = 1'b1;
    @(negedge clk);
    clr3 = 1'b0;

    // 6: 8-valid burst with reset landing mid-burst
    iv3 = 1'b1; d3 = 18'd4242; a3 = 2'b01; b3 = 2'b01;
    repeat (6) @(negedge clk);
    chk("burst_ov",   32'(ov3), 1);
    chk("burst_dout", 32'(do3), 4242);
    rst3 = 1'b1;
    #1;
    chk("mrst_ov",   32'(ov3), 0);
    chk("mrst_dout", 32'(do3), 0);
    chk("mrst_cls",  32'(cls3), 0);
    repeat (2) @(negedge clk);
    rst3 = 1'b0; iv3 = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov3) n++;
    end
    chk("mrst_flushed", 32'(n), 0);

    d3 = 18'd1111;
    iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    n = 1;
    while (!ov3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat3_cycles", 32'(n), 5);
    chk("lat3_dout",   32'(do3), 1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
